// File: rtl/div_pkg.sv
// Shared definitions for the divider responder: default operand width,
// FSM state encoding and the quotient returned on divide-by-zero.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported for a zero divisor in both signed and unsigned modes.
  localparam logic [DIV_DATA_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_axis_responder_if.sv
// Stream bundle between the EXE-stage initiator and the divider responder.
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where tvalid and tready are both 1. Once raised, tvalid and tdata hold
// steady until that edge. The responder's slave treadys are a function of
// the tvalids (both operands must be presented together), and the master
// tvalid never depends on the initiator's tready.
interface div_axis_responder_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);

  logic [DATA_W-1:0]   s_axis_dividend_tdata;
  logic                s_axis_dividend_tvalid;
  logic                s_axis_dividend_tready;
  logic [DATA_W-1:0]   s_axis_divisor_tdata;
  logic                s_axis_divisor_tvalid;
  logic                s_axis_divisor_tready;
  logic                s_div_signed;
  logic [2*DATA_W-1:0] m_axis_dout_tdata;
  logic                m_axis_dout_tvalid;
  logic                m_axis_dout_tready;

  // Responder (divider) side.
  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    input  s_div_signed,
    output m_axis_dout_tdata, m_axis_dout_tvalid,
    input  m_axis_dout_tready
  );

  // Initiator (pipeline) side.
  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    output s_div_signed,
    input  m_axis_dout_tdata, m_axis_dout_tvalid,
    output m_axis_dout_tready
  );

endinterface

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring divide step. The partial remainder is kept
// W+1 bits wide; the shifted value may wrap, but the post-add/subtract
// result always lies in [-b, b) and so is exact modulo 2^(W+1).
module div_nr_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   r_in,
  input  logic              q_msb,
  input  logic [DATA_W-1:0] b,
  input  logic              r_neg,
  output logic [DATA_W:0]   r_out,
  output logic              r_neg_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] b_ext;

  // Shift in the next dividend bit, then subtract b from a non-negative
  // remainder or add it back to a negative one.
  always_comb begin
    shifted   = {r_in[DATA_W-1:0], q_msb};
    b_ext     = {1'b0, b};
    r_out     = r_neg ? (shifted + b_ext) : (shifted - b_ext);
    r_neg_out = r_out[DATA_W];
    q_bit     = ~r_out[DATA_W];
  end

endmodule

// File: rtl/div_axis_responder.sv
// Divider responder: accepts a dividend/divisor pair, runs DATA_W
// non-restoring steps on magnitudes, applies sign fixups and presents
// {quotient, remainder} on the result stream until the initiator takes it.
module div_axis_responder
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  div_axis_responder_if.slave    axis,
  output logic                   busy,
  output div_state_e             dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_e          state;
  logic [CNT_W-1:0]    count;
  logic [DATA_W:0]     r_q;
  logic [DATA_W-1:0]   q_q;
  logic [DATA_W-1:0]   b_q;
  logic                q_sign;
  logic                r_sign;
  logic                div0;
  logic [2*DATA_W-1:0] dout_tdata;
  logic                dout_tvalid;

  logic                accept;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W:0]     r_nxt;
  logic                r_neg_nxt;
  logic                q_bit;
  logic [DATA_W-1:0]   q_fin;
  logic [DATA_W:0]     r_fix;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;

  // Both operands must arrive together; nothing is taken while flushing,
  // resetting or working on a previous pair.
  always_comb begin
    accept = (state == IDLE) && axis.s_axis_dividend_tvalid &&
             axis.s_axis_divisor_tvalid && !flush && !reset;
    a_neg  = axis.s_div_signed && axis.s_axis_dividend_tdata[DATA_W-1];
    b_neg  = axis.s_div_signed && axis.s_axis_divisor_tdata[DATA_W-1];
  end

  assign axis.s_axis_dividend_tready = accept;
  assign axis.s_axis_divisor_tready  = accept;
  assign axis.m_axis_dout_tdata      = dout_tdata;
  assign axis.m_axis_dout_tvalid     = dout_tvalid;
  assign busy                        = (state != IDLE);
  assign dbg_state                   = state;

  div_nr_step #(.DATA_W(DATA_W)) u_step (
    .r_in      (r_q),
    .q_msb     (q_q[DATA_W-1]),
    .b         (b_q),
    .r_neg     (r_q[DATA_W]),
    .r_out     (r_nxt),
    .r_neg_out (r_neg_nxt),
    .q_bit     (q_bit)
  );

  // Result of the final step: restore a negative remainder, then apply signs.
  always_comb begin
    q_fin = {q_q[DATA_W-2:0], q_bit};
    r_fix = r_neg_nxt ? (r_nxt + {1'b0, b_q}) : r_nxt;
    quot  = q_sign ? -q_fin : q_fin;
    rem   = r_sign ? -r_fix[DATA_W-1:0] : r_fix[DATA_W-1:0];
  end

  // Control FSM with the datapath registers it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      div0        <= 1'b0;
      dout_tdata  <= '0;
      dout_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // A zero divisor keeps the raw dividend in q so it can be
            // returned untouched as the remainder.
            div0   <= (axis.s_axis_divisor_tdata == '0);
            q_q    <= (axis.s_axis_divisor_tdata == '0) ? axis.s_axis_dividend_tdata :
                      a_neg ? -axis.s_axis_dividend_tdata : axis.s_axis_dividend_tdata;
            b_q    <= b_neg ? -axis.s_axis_divisor_tdata : axis.s_axis_divisor_tdata;
            q_sign <= a_neg ^ b_neg;
            r_sign <= a_neg;
            r_q    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else if (div0) begin
            dout_tdata  <= {DATA_W'(DIV0_QUOT), q_q};
            dout_tvalid <= 1'b1;
            state       <= DONE;
          end else begin
            r_q   <= r_nxt;
            q_q   <= q_fin;
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
              dout_tdata  <= {quot, rem};
              dout_tvalid <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (flush || axis.m_axis_dout_tready) begin
            dout_tvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_axis_responder.sv
// Directed and randomized bench for div_axis_responder. Expected results
// come from plain integer division in ref_div.
module tb_div_axis_responder;
  import div_pkg::*;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       busy;
  div_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  div_axis_responder_if #(.DATA_W(32)) axis ();

  div_axis_responder #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .axis      (axis),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division; zero divisor gives all-ones / raw dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_valids(input logic v);
    axis.s_axis_dividend_tvalid = v;
    axis.s_axis_divisor_tvalid  = v;
  endtask

  function automatic logic [1:0] readys();
    return {axis.s_axis_dividend_tready, axis.s_axis_divisor_tready};
  endfunction

  // Driver: present both operands, confirm they are taken on the next edge.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn);
    @(negedge clk);
    axis.s_axis_dividend_tdata = a;
    axis.s_axis_divisor_tdata  = b;
    axis.s_div_signed          = sgn;
    set_valids(1'b1);
    #1;
    check({tag, " accept_ready"}, 64'(readys()), 64'h3);
    @(posedge clk);
    #1;
    set_valids(1'b0);
    axis.s_axis_dividend_tdata = $urandom;
    axis.s_axis_divisor_tdata  = $urandom;
    axis.s_div_signed          = 1'($urandom_range(0, 1));
  endtask

  // Cycles from the accept edge until tvalid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (axis.m_axis_dout_tvalid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Take the result with operands offered in the same cycle: none may be accepted.
  task automatic collect(input string tag);
    set_valids(1'b1);
    axis.m_axis_dout_tready = 1'b1;
    @(posedge clk);
    #1;
    axis.m_axis_dout_tready = 1'b0;
    set_valids(1'b0);
    check({tag, " tvalid_after_take"}, 64'(axis.m_axis_dout_tvalid), 64'h0);
    check({tag, " bubble_no_accept"}, 64'(busy), 64'h0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int hold);
    logic [63:0] exp;
    int          lat;
    int          bad;
    exp = ref_div(a, b, sgn);
    start_op(tag, a, b, sgn);
    wait_valid(lat);
    check({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd32);
    check({tag, " result"}, axis.m_axis_dout_tdata, exp);
    if (hold > 0) begin
      bad = 0;
      set_valids(1'b1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (axis.m_axis_dout_tvalid !== 1'b1 || axis.m_axis_dout_tdata !== exp ||
            readys() !== 2'b00 || busy !== 1'b1)
          bad++;
      end
      set_valids(1'b0);
      check({tag, " held_stable"}, 64'(bad), 64'h0);
    end
    collect(tag);
  endtask

  initial begin : main
    int bad;
    int seen;
    logic [31:0] ra, rb;
    logic        rs;

    // Reset
    reset = 1'b1;
    flush = 1'b0;
    axis.s_axis_dividend_tdata = '0;
    axis.s_axis_divisor_tdata  = '0;
    axis.s_div_signed          = 1'b0;
    axis.m_axis_dout_tready    = 1'b0;
    set_valids(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'h0);
    check("reset tvalid", 64'(axis.m_axis_dout_tvalid), 64'h0);
    check("reset tdata", axis.m_axis_dout_tdata, 64'h0);
    check("reset readys", 64'(readys()), 64'h0);
    check("reset state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Directed arithmetic cases
    run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 0);
    check("udiv_100_7 model", ref_div(32'd100, 32'd7, 1'b0), {32'd14, 32'd2});
    run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("div0_u", 32'd5, 32'd0, 1'b0, 0);
    run_op("div0_s", 32'd5, 32'd0, 1'b1, 0);
    run_op("div0_s_neg", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("udiv_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

    // Backpressure: result held for 10 cycles
    run_op("backpressure", 32'd1000, 32'd33, 1'b1, 10);

    // Dividend alone must not start anything
    @(negedge clk);
    axis.s_axis_dividend_tvalid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (readys() !== 2'b00 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    axis.s_axis_dividend_tvalid = 1'b0;
    check("dividend_only no_start", 64'(bad), 64'h0);

    // Flush in the accept cycle wins
    @(negedge clk);
    set_valids(1'b1);
    flush = 1'b1;
    #1;
    check("flush_at_accept readys", 64'(readys()), 64'h0);
    @(posedge clk);
    #1;
    set_valids(1'b0);
    flush = 1'b0;
    check("flush_at_accept busy", 64'(busy), 64'h0);

    // Flush when count reaches 10
    start_op("flush_cnt10", 32'd123456, 32'd789, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_cnt10 idle", 64'(dbg_state), 64'(IDLE));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (axis.m_axis_dout_tvalid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("flush_cnt10 no_result", 64'(seen), 64'h0);

    // Async reset when count reaches 20
    start_op("reset_cnt20", 32'd987654, 32'd321, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_cnt20 busy", 64'(busy), 64'h0);
    check("reset_cnt20 tvalid", 64'(axis.m_axis_dout_tvalid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset", 32'hFFFF_FFFF, 32'h10, 1'b0, 0);
    check("after_reset model", ref_div(32'hFFFF_FFFF, 32'h10, 1'b0), {32'h0FFF_FFFF, 32'hF});

    // Flush while the result waits drops it
    start_op("flush_done", 32'd77, 32'd5, 1'b0);
    wait_valid(seen);
    check("flush_done valid", 64'(axis.m_axis_dout_tvalid), 64'h1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done dropped", 64'({axis.m_axis_dout_tvalid, busy}), 64'h0);

    // Randomized operands, signs and backpressure
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", n), ra, rb, rs, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
